axis_bram_adapter_v1_0_out_fifo: RTL and testbench

- Output decoupling stage directly downstream of the adapter controller's read path.
- Absorbs words unpacked from a BRAM line, plus their tlast flag, and presents them on a standard AXI4-Stream master with real tready backpressure.
- The upstream read path has 2-cycle BRAM latency and cannot stop instantly. This block therefore raises its accept signal early, reserving SLACK entries for words already in flight.

---
 rtl/axis_bram_adapter_v1_0_out_fifo.sv | 194 +++++++++++++++++++
 tb/tb_axis_bram_adapter_v1_0_out_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bram_adapter_v1_0_out_fifo.sv
// -----------------------------------------------------------------------------
// axis_bram_adapter_v1_0_out_fifo
//
// Output decoupling FIFO between the adapter read path and an AXI4-Stream
// master. Words and their tlast flag are stored together. The output is
// first-word-fall-through, so a word pushed in cycle N is visible in cycle
// N+1.
//
// s_accep is raised early. It keeps SLACK entries free for words that the
// 2-cycle BRAM read path has already launched. A producer that stops
// launching within SLACK cycles of s_accep falling can never overflow the
// FIFO.
//
// Optional build macro: OUT_FIFO_PKT_CNT_EN
//   Defining it adds two outputs:
//   - pkt_cnt: count of tlast pops, 16 bits, wraps from 0xFFFF to 0.
//   - pkt_pending: 1 while any stored entry carries last=1.
//   Leaving it undefined removes both ports and their logic.
//
// SLACK must lie in 1 .. 2**DEPTH_LOG2-1.
// -----------------------------------------------------------------------------
module axis_bram_adapter_v1_0_out_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 3,
    parameter int SLACK      = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_accep,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
`ifdef OUT_FIFO_PKT_CNT_EN
    ,
    output logic [15:0]           pkt_cnt,
    output logic                  pkt_pending
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Occupancy constants, sized to the level counter.
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL   = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   ACCEP_LEVEL  = (DEPTH_LOG2+1)'(DEPTH - SLACK);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE      = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_ZERO     = '0;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE      = DEPTH_LOG2'(1);

    // Each entry is {last, data}.
    logic [DATA_WIDTH:0]     mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     level_q,  level_d;
    logic                    overflow_q, overflow_d;

    logic                    full;
    logic                    empty;
    logic                    pop;
    logic                    push;
    logic                    drop;

    // -------------------------------------------------------------------------
    // Status and handshake decode. Everything is derived from the registered
    // level, so there is no path from s_valid to m_axis_tvalid.
    // -------------------------------------------------------------------------
    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == LVL_ZERO);

    assign m_axis_tvalid = !empty;
    assign pop           = m_axis_tvalid && m_axis_tready;

    // When full, a simultaneous pop frees a slot, so the write still lands.
    assign push = s_valid && (!full || pop);
    assign drop = s_valid && full && !pop;

    assign s_accep  = (level_q < ACCEP_LEVEL);
    assign level    = level_q;
    assign overflow = overflow_q;

    // First-word-fall-through: the head entry drives the stream directly.
    // The head stays stable until it is popped.
    assign {m_axis_tlast, m_axis_tdata} = mem_q[rd_ptr_q];

    // Storage write. Contents need no reset, because tvalid hides stale
    // entries.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= {s_last, s_data};
        end
    end

    // Next-state for pointers, level and the sticky overflow flag.
    // flush overrides any push or pop in the same cycle.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                level_d = level_q + LVL_ONE;
            end else if (pop && !push) begin
                level_d = level_q - LVL_ONE;
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Pointer, level and overflow registers, cleared asynchronously by rstn.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef OUT_FIFO_PKT_CNT_EN
    // -------------------------------------------------------------------------
    // Packet accounting. A separate count of stored last flags avoids
    // scanning the whole memory to decide whether a packet end is buffered.
    // -------------------------------------------------------------------------
    logic [15:0]           pkt_cnt_q,  pkt_cnt_d;
    logic [DEPTH_LOG2:0]   last_cnt_q, last_cnt_d;
    logic                  last_in;
    logic                  last_out;

    assign last_in  = push && s_last;
    assign last_out = pop && m_axis_tlast;

    assign pkt_cnt     = pkt_cnt_q;
    assign pkt_pending = (last_cnt_q != LVL_ZERO);

    // Next-state for the packet counter and the stored-last counter.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        last_cnt_d = last_cnt_q;

        if (flush) begin
            pkt_cnt_d  = '0;
            last_cnt_d = '0;
        end else begin
            if (last_out) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
            if (last_in && !last_out) begin
                last_cnt_d = last_cnt_q + LVL_ONE;
            end else if (last_out && !last_in) begin
                last_cnt_d = last_cnt_q - LVL_ONE;
            end
        end
    end

    // Packet accounting registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pkt_cnt_q  <= '0;
            last_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            last_cnt_q <= last_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_axis_bram_adapter_v1_0_out_fifo.sv
// -----------------------------------------------------------------------------
// Testbench for axis_bram_adapter_v1_0_out_fifo.
//
// The reference model is a queue of {last, data} entries. Each cycle the
// bench applies the FIFO rules to it: pop when non-empty and ready, push
// when not full or popping, drop otherwise, and flush clears everything.
// Before new inputs are driven, the DUT outputs are compared with the model.
//
// Optional build macro: OUT_FIFO_PKT_CNT_EN (also checks the packet outputs).
// -----------------------------------------------------------------------------
module tb_axis_bram_adapter_v1_0_out_fifo;

    localparam int DW    = 32;
    localparam int DL2   = 3;
    localparam int SLACK = 3;
    localparam int DEPTH = 1 << DL2;

    logic          clk;
    logic          rstn;
    logic          flush;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_accep;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [DL2:0]  level;
    logic          overflow;
`ifdef OUT_FIFO_PKT_CNT_EN
    logic [15:0]   pkt_cnt;
    logic          pkt_pending;
`endif

    axis_bram_adapter_v1_0_out_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH_LOG2 (DL2),
        .SLACK      (SLACK)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .flush         (flush),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_accep       (s_accep),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .level         (level),
        .overflow      (overflow)
`ifdef OUT_FIFO_PKT_CNT_EN
        ,
        .pkt_cnt       (pkt_cnt),
        .pkt_pending   (pkt_pending)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state.
    logic [DW:0] mq[$];
    logic [DW:0] popped_q[$];
    logic        m_ovf;
    int          m_pkt;

    int total_cnt;
    int bad_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Compare all visible DUT outputs with the model. This runs on the
    // negative edge, before the next inputs are driven.
    task automatic compare_outputs();
        bit pend;
        check("level", 64'(level), 64'(mq.size()));
        check("tvalid", 64'(m_axis_tvalid), 64'(mq.size() != 0));
        check("s_accep", 64'(s_accep), 64'(mq.size() < DEPTH - SLACK));
        check("overflow", 64'(overflow), 64'(m_ovf));
        if (mq.size() != 0) begin
            check("tdata", 64'(m_axis_tdata), 64'(mq[0][DW-1:0]));
            check("tlast", 64'(m_axis_tlast), 64'(mq[0][DW]));
        end
        pend = 1'b0;
        foreach (mq[i]) if (mq[i][DW]) pend = 1'b1;
`ifdef OUT_FIFO_PKT_CNT_EN
        check("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt & 16'hFFFF));
        check("pkt_pending", 64'(pkt_pending), 64'(pend));
`else
        if (pend && m_pkt < 0) $display("unreachable");
`endif
    endtask

    // Run one clock transaction: check the outputs, drive the inputs,
    // advance the model, then let the DUT take the posedge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic l,
                         input logic r, input logic f);
        bit          full;
        bit          do_pop;
        bit          do_push;
        logic [DW:0] head;
        compare_outputs();
        s_valid       = v;
        s_data        = d;
        s_last        = l;
        m_axis_tready = r;
        flush         = f;
        full    = (mq.size() == DEPTH);
        do_pop  = (mq.size() != 0) && r;
        do_push = v && (!full || do_pop);
        if (f) begin
            mq.delete();
            m_ovf = 1'b0;
            m_pkt = 0;
        end else begin
            if (do_pop) begin
                head = mq.pop_front();
                popped_q.push_back(head);
                if (head[DW]) m_pkt++;
                $display("pop data=%08h last=%0d", head[DW-1:0], head[DW]);
            end
            if (do_push) mq.push_back({l, d});
            if (v && full && !do_pop) m_ovf = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic r);
        cycle(1'b0, '0, 1'b0, r, 1'b0);
    endtask

    initial begin
        logic [1:0] pv;
        int         pidx[2];
        int         launched;
        int         guard;
        bit         launch;
        logic       dv;
        int         di;

        total_cnt = 0;
        bad_cnt   = 0;
        m_ovf     = 1'b0;
        m_pkt     = 0;
        rstn          = 1'b0;
        flush         = 1'b0;
        s_valid       = 1'b0;
        s_data        = '0;
        s_last        = 1'b0;
        m_axis_tready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        compare_outputs();
        rstn = 1'b1;
        @(negedge clk);

        // Single word: visible the next cycle, then popped.
        $display("single word");
        cycle(1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Five words with the stream stalled: s_accep falls at level 5.
        $display("five words stalled");
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h10 + i, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 6; i++) idle(1'b1);

        // Fill to 8, then push and pop together while full.
        $display("full with simultaneous pop");
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'h100 + i, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h108, 1'b0, 1'b1, 1'b0);
        idle(1'b0);

        // Full and stalled: the write is dropped.
        $display("drop while full");
        cycle(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check("drop_ovf", 64'(overflow), 64'd1);

        // Drain to 4, then flush together with a push and a pop.
        $display("flush with traffic");
        for (int i = 0; i < 4; i++) idle(1'b1);
        cycle(1'b1, 32'hBEEF, 1'b1, 1'b1, 1'b1);
        check("flush_level", 64'(level), 64'd0);
        check("flush_ovf", 64'(overflow), 64'd0);
        check("flush_accep", 64'(s_accep), 64'd1);
        idle(1'b0);

        // 36-word packet from a 2-cycle-latency producer that honours
        // s_accep, with random tready.
        $display("36 word packet");
        popped_q.delete();
        pv       = '0;
        pidx[0]  = 0;
        pidx[1]  = 0;
        launched = 0;
        guard    = 0;
        while ((popped_q.size() < 36) && (guard < 3000)) begin
            dv = pv[1];
            di = pidx[1];
            launch = (launched < 36) && s_accep && ($urandom_range(0, 3) != 0);
            pv[1]   = pv[0];
            pidx[1] = pidx[0];
            pv[0]   = launch;
            pidx[0] = launched;
            if (launch) launched++;
            cycle(dv, 32'(di), dv && (di == 35), 1'($urandom_range(0, 1)), 1'b0);
            guard++;
        end
        check("pkt_timeout", 64'(guard < 3000), 64'd1);
        check("pkt_words", 64'(popped_q.size()), 64'd36);
        foreach (popped_q[i]) begin
            check("pkt_order", 64'(popped_q[i][DW-1:0]), 64'(i));
            check("pkt_last", 64'(popped_q[i][DW]), 64'(i == 35));
        end
        check("pkt_ovf", 64'(overflow), 64'd0);
`ifdef OUT_FIFO_PKT_CNT_EN
        check("pkt_cnt_one", 64'(pkt_cnt), 64'd1);
`endif

        // Random traffic, including overflows and occasional flushes.
        $display("random traffic");
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 49) == 0));
        end

        // Asynchronous reset mid-traffic.
        $display("async reset");
        for (int i = 0; i < 6; i++) cycle(1'b1, 32'h2000 + i, 1'b0, 1'b0, 1'b0);
        rstn = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        m_pkt = 0;
        compare_outputs();
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h3000 + i, 1'(i == 3), 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        compare_outputs();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
